serial_addsub_digit: RTL
========================

# serial_addsub_digit

Digit-serial adder/subtractor, successor to the single-bit serial adder: processes DIGIT_W bits per cycle, least-significant digit first, with a per-word add/subtract mode, a registered output stream, end-of-word carry/borrow reporting and a word-length guard. It sits between a digit-serial producer (vld/last framing) and a digit-serial consumer in the sequential-arithmetic datapath.

## Interface
- DIGIT_W, default 4: bits per digit, ≥1.
- MAX_DIGITS, default 8: maximum digits per word, ≥1.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- vld  input  1  a, b, sub and last are valid this cycle.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- sub  input  1  mode: 0 = A+B, 1 = A−B. Sampled only on the first digit of a word.
- last  input  1  final digit of the word. Ignored when vld=0.
- out_vld  output  1  output digit valid.
- out_sum  output  DIGIT_W  result digit.
- out_last  output  1  final result digit of the word.
- out_carry  output  1  carry out of the word (add) or no-borrow flag (sub: 1 = A≥B unsigned). Meaningful only with out_last.
- out_len_err  output  1  word was force-terminated at MAX_DIGITS. Meaningful only with out_last.
- out_ovf  output  1  signed two's-complement overflow. Meaningful only with out_last.

## Operation
- State: IDLE (next valid digit is the first of a word) and BUSY (mid-word). Internal registers: carry, latched mode, digit counter (clog2(MAX_DIGITS+1) bits).
- First digit (IDLE, vld=1): mode := sub; effective carry-in = sub. Later digits: carry-in = stored carry; sub input is ignored.
- Per valid digit: {c_out, s} = a + (mode ? ~b : b) + carry_in, computed at DIGIT_W+1 bits. carry := c_out; counter increments.
- End of word occurs when vld=1 and (last=1 or counter reaches MAX_DIGITS on this digit). At end of word: carry and counter are cleared, state returns to IDLE, and the output is flagged as last. If last=0 at that point, out_len_err=1.
- With last=1 on the MAX_DIGITS-th digit, out_len_err=0.
- A single-digit word (vld=1, last=1 in IDLE) is legal.
- vld=0: no state change. last, a, b and sub are ignored.
- Signed overflow = carry into the MSB of the final digit XOR c_out of the final digit.

## Timing
- Latency is 1 cycle. Outputs are registered. A valid input at cycle n produces out_vld=1 with its digit at cycle n+1.
- out_vld=0 in cycles following vld=0. Output fields hold their previous values in that case; the consumer must qualify them with out_vld.
- Throughput is one digit per cycle. No backpressure.
- Reset values: out_vld=0, out_sum=0, out_last=0, out_carry=0, out_len_err=0, out_ovf=0. Internal carry=0, counter=0, state IDLE.
- Reset mid-word: the partial word is abandoned. The next valid digit starts a new word with a freshly sampled mode.
- rst has priority over vld in the same cycle; the input digit is dropped.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: the overflow logic is compiled in and out_ovf behaves as specified.
- Not defined: out_ovf is tied to 0 and the MSB-carry logic is removed. All other outputs are identical in both builds.

## Test plan
DIGIT_W=4, MAX_DIGITS=4 unless stated. Digits are listed LSB first.
- Add 0x00FF+0x0001: a=F,F,0,0; b=1,0,0,0; sub=0; last on 4th digit -> out_sum=0,0,1,0, out_carry=0, out_len_err=0, each digit one cycle after its input.
- Sub 0x0003−0x0005: a=3,0,0,0; b=5,0,0,0; sub=1 -> out_sum=E,F,F,F, out_carry=0, out_ovf=0. Then 0x0005−0x0003 -> 2,0,0,0 with out_carry=1. Toggling sub mid-word has no effect.
- Framing: same stimulus as the first scenario with vld=0 gaps and last=1 pulsed during the gaps -> identical result digits; out_vld high only on the 4 valid cycles; no premature out_last.
- Overflow: 0x7FFF+0x0001 -> 0,0,0,8. With SERIAL_ADDSUB_OVF_EN: out_ovf=1. Without it: out_ovf=0. Also 0x8000−0x0001 -> F,F,F,7 with out_ovf=1 (macro defined).
- Length guard: 5 valid digits with last=0, each a=F and b=1 -> 4th output digit has out_last=1 and out_len_err=1. The 5th digit starts a new word with carry-in 0 -> out_sum=0.
- Reset mid-word: assert rst after 2 digits of an add whose carry is pending -> outputs 0 next cycle. A following single-digit word a=1, b=1, last=1 -> out_sum=2, out_last=1, out_carry=0.

Source files
------------

// File: rtl/serial_addsub_digit_if.sv
// Digit-serial operand/result bus for serial_addsub_digit.
// master: digit producer (drives operands, observes results).
// slave: the adder/subtractor (consumes operands, drives results).
interface serial_addsub_digit_if #(
    parameter int unsigned DIGIT_W = 4
);
    logic               vld;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               sub;
    logic               last;

    logic               out_vld;
    logic [DIGIT_W-1:0] out_sum;
    logic               out_last;
    logic               out_carry;
    logic               out_len_err;
    logic               out_ovf;

    modport master (
        output vld, a, b, sub, last,
        input  out_vld, out_sum, out_last, out_carry, out_len_err, out_ovf
    );

    modport slave (
        input  vld, a, b, sub, last,
        output out_vld, out_sum, out_last, out_carry, out_len_err, out_ovf
    );
endinterface

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, LSB digit first, one digit per cycle.
// The mode (add/sub) is latched on the first digit of each word.
// A word ends on last=1 or when MAX_DIGITS digits have been taken.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables signed-overflow
// reporting on out_ovf; without it out_ovf is constant 0.
module serial_addsub_digit #(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_addsub_digit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned SUM_W = DIGIT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               carry;
    logic               carry_next;
    logic               mode;
    logic               mode_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic               vld_q;
    logic               vld_next;
    logic [DIGIT_W-1:0] sum_q;
    logic [DIGIT_W-1:0] sum_next;
    logic               last_q;
    logic               last_next;
    logic               cout_q;
    logic               cout_next;
    logic               len_err_q;
    logic               len_err_next;
    logic               ovf_q;
    logic               ovf_next;

    logic               mode_eff;
    logic               carry_in;
    logic [DIGIT_W-1:0] b_eff;
    logic [SUM_W-1:0]   full;
    logic               at_max;
    logic               word_end;
    logic               ovf_c;

    // First digit of a word takes mode and carry-in from sub; later digits use the latched values.
    assign mode_eff = (state == IDLE) ? bus.sub : mode;
    assign carry_in = (state == IDLE) ? bus.sub : carry;
    assign b_eff    = mode_eff ? ~bus.b : bus.b;
    assign full     = SUM_W'(bus.a) + SUM_W'(b_eff) + SUM_W'(carry_in);
    assign at_max   = (count == CNT_W'(MAX_DIGITS - 1));
    assign word_end = bus.last || at_max;

`ifdef SERIAL_ADDSUB_OVF_EN
    // Carry into the MSB is recovered as a^b^sum at the MSB position.
    assign ovf_c = (bus.a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ full[DIGIT_W-1]) ^ full[DIGIT_W];
`else
    assign ovf_c = 1'b0;
`endif

    // Next-state and next-output logic; idle cycles keep state and hold the output fields.
    always_comb begin
        state_next   = state;
        carry_next   = carry;
        mode_next    = mode;
        count_next   = count;
        vld_next     = 1'b0;
        sum_next     = sum_q;
        last_next    = last_q;
        cout_next    = cout_q;
        len_err_next = len_err_q;
        ovf_next     = ovf_q;

        if (bus.vld) begin
            vld_next     = 1'b1;
            sum_next     = full[DIGIT_W-1:0];
            last_next    = word_end;
            cout_next    = full[DIGIT_W];
            len_err_next = word_end && !bus.last;
            ovf_next     = ovf_c;
            mode_next    = mode_eff;
            if (word_end) begin
                state_next = IDLE;
                carry_next = 1'b0;
                count_next = '0;
            end else begin
                state_next = BUSY;
                carry_next = full[DIGIT_W];
                count_next = count + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            carry     <= 1'b0;
            mode      <= 1'b0;
            count     <= '0;
            vld_q     <= 1'b0;
            sum_q     <= '0;
            last_q    <= 1'b0;
            cout_q    <= 1'b0;
            len_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_next;
            carry     <= carry_next;
            mode      <= mode_next;
            count     <= count_next;
            vld_q     <= vld_next;
            sum_q     <= sum_next;
            last_q    <= last_next;
            cout_q    <= cout_next;
            len_err_q <= len_err_next;
            ovf_q     <= ovf_next;
        end
    end

    assign bus.out_vld     = vld_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_last    = last_q;
    assign bus.out_carry   = cout_q;
    assign bus.out_len_err = len_err_q;
    assign bus.out_ovf     = ovf_q;
endmodule
